// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one single-port data memory between the core and host ports,
// with a bounded burst for the current owner and one-cycle read return.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [0:0] CORE = 1'b0;
  localparam logic [0:0] HOST = 1'b1;
  logic [0:0]    owner;
  logic [BW-1:0] burst_cnt;
  logic [1:0]    rd_pend;
  logic          sat, pick, gnt;
  // pick=1 selects the host; under contention the owner keeps it until its burst saturates
  always_comb begin
    sat         = burst_cnt == BW'(MAX_BURST);
    pick        = (core_req & host_req) ? owner ^ sat : host_req;
    gnt         = reset_n & (core_req | host_req);
    host_gnt    = gnt & pick;
    core_gnt    = gnt & ~pick;
    mem_en      = gnt;
    mem_we      = gnt & (pick ? host_we : core_we);
    mem_addr    = gnt ? (pick ? host_addr : core_addr) : '0;
    mem_wdata   = gnt ? (pick ? host_wdata : core_wdata) : '0;
    core_rvalid = reset_n & rd_pend[0];
    host_rvalid = reset_n & rd_pend[1];
    core_rdata  = core_rvalid ? mem_rdata : '0;
    host_rdata  = host_rvalid ? mem_rdata : '0;
    busy        = core_rvalid | host_rvalid | gnt;
  end
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      owner     <= CORE;
      burst_cnt <= '0;
      rd_pend   <= '0;
    end else begin
      rd_pend <= {host_gnt & ~host_we, core_gnt & ~core_we};
      if (!gnt) burst_cnt <= '0;
      else if (pick == owner) burst_cnt <= sat ? burst_cnt : burst_cnt + BW'(1);
      else begin
        owner     <= pick ? HOST : CORE;
        burst_cnt <= BW'(1);
      end
    end
  end
endmodule
